// File: rtl/adc_pkg.sv
// Shared types and helpers for the LTC2308-class ADC scan controller.
// The config word is single-ended, unipolar, with sleep disabled.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CST   = 3'd1,
    ST_CONV  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_NEXT  = 3'd4
  } state_e;

  // Bit order follows the ADC: S/D, O/S, S1, S0, UNI, SLP.
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2:1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock divider: a registered SCK that idles low.
// It also produces one-cycle enables for the edges that drive SCK high or low.
module adc_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic sck_o,
  output logic sck_rise_en_o,
  output logic sck_fall_en_o
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;

  assign sck_o         = sck_q;
  assign sck_rise_en_o = run_i && (cnt_q == '0) && !sck_q;
  assign sck_fall_en_o = run_i && (cnt_q == '0) && sck_q;

  // Half-period counter; SCK toggles whenever the counter expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q <= DIV_LAST;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// SPI master that scans a channel mask on an LTC2308-class SAR ADC.
// The config word sent in one frame selects the channel converted in the next frame.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int CFG_W    = 6,
  parameter int N_CH     = 8,
  parameter int SCK_DIV  = 2,
  parameter int CONV_CYC = 80,
  parameter int CST_CYC  = 2,
  parameter int CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [DATA_W-1:0] result,
  output logic [CH_W-1:0]   result_ch,
  output logic              result_valid,
  output logic              busy,
  output logic              ADC_CONVST,
  output logic              ADC_SCK,
  output logic              ADC_SDI,
  input  logic              ADC_SDO
);

  localparam int SHIFT_CYC = 2 * SCK_DIV * DATA_W;
  localparam int MAX_CYC   = (SHIFT_CYC > CONV_CYC) ? SHIFT_CYC : CONV_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CST_LAST   = CNT_W'(CST_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [N_CH-1:0]     mask_q;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d, conv_ch_q;
  logic [CH_W-1:0]     nxt_ch_s, first_ch_s;
  logic                wrap_s, relatch_s;
  logic                primed_q, last_q, busy_q, convst_q, sdi_q, result_valid_q;
  logic [DATA_W-1:0]   sdi_sr_q, sdo_sr_q, result_q, cfg_frame_s;
  logic [CH_W-1:0]     result_ch_q;
  logic                sck_s, sck_rise_en_s, sck_fall_en_s;

  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .run_i         (state_d == ST_SHIFT),
    .sck_o         (sck_s),
    .sck_rise_en_o (sck_rise_en_s),
    .sck_fall_en_o (sck_fall_en_s)
  );

  // Next enabled channel after cur_ch_q, flagging when the search passes N_CH-1.
  always_comb begin
    nxt_ch_s = cur_ch_q;
    wrap_s   = 1'b1;
    for (int i = N_CH; i >= 1; i--) begin
      nxt_ch_s = mask_q[CH_W'((int'(cur_ch_q) + i) % N_CH)] ? CH_W'((int'(cur_ch_q) + i) % N_CH) : nxt_ch_s;
      wrap_s   = mask_q[CH_W'((int'(cur_ch_q) + i) % N_CH)] ? ((int'(cur_ch_q) + i) >= N_CH) : wrap_s;
    end
  end

  // Lowest enabled channel of the live mask, used at scan start and on a continuous wrap.
  always_comb begin
    first_ch_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      first_ch_s = ch_mask[i] ? CH_W'(i) : first_ch_s;
    end
  end

  assign relatch_s   = continuous && (ch_mask != '0);
  assign cfg_frame_s = DATA_W'(cfg_word(3'(cur_ch_d))) << (DATA_W - CFG_W);

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (start && (ch_mask != '0) && !busy_q) ? ST_CST : ST_IDLE;
      ST_CST:   state_d = (cnt_q == CST_LAST) ? ST_CONV : ST_CST;
      ST_CONV:  state_d = (cnt_q == CONV_LAST) ? ST_SHIFT : ST_CONV;
      ST_SHIFT: state_d = (cnt_q == SHIFT_LAST) ? ST_NEXT : ST_SHIFT;
      ST_NEXT:  state_d = last_q ? ST_IDLE : ST_CST;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Channel whose config word goes out in the coming frame.
  always_comb begin
    cur_ch_d = cur_ch_q;
    case (state_q)
      ST_IDLE: cur_ch_d = (state_d == ST_CST) ? first_ch_s : cur_ch_q;
      ST_NEXT: cur_ch_d = last_q ? cur_ch_q : ((wrap_s && relatch_s) ? first_ch_s : nxt_ch_s);
      default: cur_ch_d = cur_ch_q;
    endcase
  end

  // Sequencer state, scan bookkeeping, SDI/SDO shifters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      cur_ch_q       <= '0;
      conv_ch_q      <= '0;
      primed_q       <= 1'b0;
      last_q         <= 1'b0;
      busy_q         <= 1'b0;
      convst_q       <= 1'b0;
      sdi_q          <= 1'b0;
      sdi_sr_q       <= '0;
      sdo_sr_q       <= '0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_ch_q       <= cur_ch_d;
      convst_q       <= (state_d == ST_CST);
      result_valid_q <= 1'b0;
      cnt_q          <= ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          busy_q <= (state_d == ST_CST);
          if (state_d == ST_CST) begin
            mask_q   <= ch_mask;
            primed_q <= 1'b0;
            last_q   <= 1'b0;
          end
        end
        ST_NEXT: begin
          // The prime frame's data belongs to no requested channel.
          if (primed_q) begin
            result_q       <= sdo_sr_q;
            result_ch_q    <= conv_ch_q;
            result_valid_q <= 1'b1;
          end
          if (!last_q) begin
            primed_q  <= 1'b1;
            conv_ch_q <= cur_ch_q;
            if (wrap_s && relatch_s) mask_q <= ch_mask;
            if (wrap_s && !relatch_s) last_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if ((state_d == ST_CST) && (state_q != ST_CST)) begin
        sdi_q    <= cfg_frame_s[DATA_W-1];
        sdi_sr_q <= cfg_frame_s << 1;
        sdo_sr_q <= '0;
      end else if (sck_fall_en_s) begin
        sdi_q    <= sdi_sr_q[DATA_W-1];
        sdi_sr_q <= sdi_sr_q << 1;
      end
      if (sck_rise_en_s) sdo_sr_q <= {sdo_sr_q[DATA_W-2:0], ADC_SDO};
    end
  end

  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign ADC_CONVST   = convst_q;
  assign ADC_SCK      = sck_s;
  assign ADC_SDI      = sdi_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural ADC that decodes SDI and returns
// a channel-dependent word, so the pipeline and channel order are checked end to end.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, start, continuous;
  logic [7:0]  ch_mask;
  logic [11:0] result;
  logic [2:0]  result_ch;
  logic        result_valid, busy, ADC_CONVST, ADC_SCK, ADC_SDI;
  logic        adc_sdo = 1'b0;

  adc_scan_ctrl #(
    .DATA_W(12), .CFG_W(6), .N_CH(8), .SCK_DIV(3), .CONV_CYC(10), .CST_CYC(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .result(result), .result_ch(result_ch), .result_valid(result_valid), .busy(busy),
    .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .ADC_SDO(adc_sdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] adc_data(input logic [2:0] ch);
    return 12'hA5C ^ ({9'd0, ch} * 12'h111);
  endfunction

  // ADC model: MSB ready after CONVST, next bit after each SCK fall.
  int          m_frames = 0;
  int          m_idx = -1;
  logic [11:0] m_word = 12'h000;
  logic [2:0]  m_next_ch = 3'd0;
  always @(posedge ADC_CONVST or negedge ADC_SCK) begin
    if (ADC_CONVST) begin
      m_frames++;
      m_word  = adc_data(m_next_ch);
      m_idx   = 11;
      adc_sdo = m_word[11];
    end else begin
      m_idx   = m_idx - 1;
      adc_sdo = (m_idx >= 0) ? m_word[m_idx] : 1'b0;
    end
  end

  // ADC model: SDI captured on SCK rise; config decides the next conversion channel.
  int          m_rises = 0;
  logic [11:0] m_cap = 12'h000;
  logic [11:0] m_sdi_log [256];
  always @(posedge ADC_SCK or posedge ADC_CONVST) begin
    if (ADC_CONVST) begin
      m_rises = 0;
    end else begin
      m_cap = {m_cap[10:0], ADC_SDI};
      m_rises++;
      if (m_rises == 12) begin
        m_sdi_log[(m_frames - 1) & 255] = m_cap;
        m_next_ch = {m_cap[9], m_cap[8], m_cap[10]};
      end
    end
  end

  // Pin timing, strobe log and busy-fall monitor, sampled mid-cycle.
  logic conv_prev = 1'b0, sck_prev = 1'b0, sdi_prev = 1'b0, busy_prev = 1'b0;
  int   t_fall_cyc = 0, t_rise_cyc = 0, t_first_off = -1;
  int   t_rises = 0, t_off_bad = 0, t_per_bad = 0, t_sdi_bad = 0, t_busy_fall = 0;
  logic t_pending = 1'b0;
  int   s_n = 0;
  int   s_ch [64];
  int   s_res [64];
  int   s_cyc [64];
  always @(negedge clk) begin
    if (conv_prev && !ADC_CONVST) begin
      t_fall_cyc = cyc;
      t_pending  = 1'b1;
    end
    if (!sck_prev && ADC_SCK) begin
      t_rises++;
      if (t_pending) begin
        t_first_off = cyc - t_fall_cyc;
        if (t_first_off != 10) t_off_bad++;
        t_pending = 1'b0;
      end else if (cyc - t_rise_cyc != 6) begin
        t_per_bad++;
      end
      t_rise_cyc = cyc;
      if (ADC_SDI !== sdi_prev) t_sdi_bad++;
    end
    if (result_valid === 1'b1 && s_n < 64) begin
      s_ch[s_n]  = int'(result_ch);
      s_res[s_n] = int'(result);
      s_cyc[s_n] = cyc;
      s_n++;
    end
    if (busy_prev && !busy) t_busy_fall = cyc;
    conv_prev = ADC_CONVST;
    sck_prev  = ADC_SCK;
    sdi_prev  = ADC_SDI;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
    @(negedge clk);
  endtask

  int f0, s0, r0, ob0, pb0, sb0;

  initial begin
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_convst", ADC_CONVST, 1'b0);
    check("rst_sck", ADC_SCK, 1'b0);
    check("rst_sdi", ADC_SDI, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_result", result, 12'h000);
    check("rst_result_ch", result_ch, 3'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty mask: start is ignored.
    f0 = m_frames;
    pulse_start(8'h00);
    repeat (20) @(negedge clk);
    check("mask0_busy", busy, 1'b0);
    check("mask0_frames", m_frames - f0, 0);

    // Single channel, single shot: prime plus one frame.
    f0 = m_frames; s0 = s_n; r0 = t_rises; ob0 = t_off_bad; pb0 = t_per_bad; sb0 = t_sdi_bad;
    pulse_start(8'h01);
    check("single_busy_set", busy, 1'b1);
    wait_idle("single", 1000);
    check("single_frames", m_frames - f0, 2);
    check("single_nstrobe", s_n - s0, 1);
    check("single_ch", s_ch[s0], 0);
    check("single_result", s_res[s0], 12'hA5C);
    check("single_busy_drop", t_busy_fall - s_cyc[s0], 1);
    check("single_sdi_f0", m_sdi_log[f0 & 255], 12'h880);
    check("sck_first_offset", t_first_off, 10);
    check("sck_offset_bad", t_off_bad - ob0, 0);
    check("sck_period_bad", t_per_bad - pb0, 0);
    check("sdi_unstable", t_sdi_bad - sb0, 0);
    check("sck_rises", t_rises - r0, 24);
    check("result_hold", result, 12'hA5C);
    check("valid_low_idle", result_valid, 1'b0);

    // Three channels; a second start while busy must not add frames.
    f0 = m_frames; s0 = s_n; r0 = t_rises; sb0 = t_sdi_bad;
    pulse_start(8'hA4);
    repeat (100) @(negedge clk);
    pulse_start(8'hFF);
    wait_idle("multi", 2000);
    check("multi_frames", m_frames - f0, 4);
    check("multi_nstrobe", s_n - s0, 3);
    check("multi_ch0", s_ch[s0], 2);
    check("multi_ch1", s_ch[s0 + 1], 5);
    check("multi_ch2", s_ch[s0 + 2], 7);
    check("multi_res0", s_res[s0], 12'h87E);
    check("multi_res1", s_res[s0 + 1], 12'hF09);
    check("multi_res2", s_res[s0 + 2], 12'hD2B);
    check("multi_sdi_f0", m_sdi_log[f0 & 255], 12'h980);
    check("multi_sdi_f1", m_sdi_log[(f0 + 1) & 255], 12'hE80);
    check("multi_sdi_f2", m_sdi_log[(f0 + 2) & 255], 12'hF80);
    check("multi_rises", t_rises - r0, 48);
    check("multi_sdi_unstable", t_sdi_bad - sb0, 0);

    // Continuous scan of ch 0 and 7, cleared after the fifth strobe.
    f0 = m_frames; s0 = s_n;
    continuous = 1'b1;
    pulse_start(8'h81);
    for (int i = 0; i < 3000 && (s_n - s0) < 5; i++) @(negedge clk);
    check("cont_reached5", (s_n - s0) >= 5, 1'b1);
    continuous = 1'b0;
    wait_idle("cont", 3000);
    check("cont_nstrobe", s_n - s0, 8);
    check("cont_frames", m_frames - f0, 9);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("cont_ch%0d", k), s_ch[s0 + k], ((k % 2) == 0) ? 0 : 7);
      check($sformatf("cont_res%0d", k), s_res[s0 + k], ((k % 2) == 0) ? 12'hA5C : 12'hD2B);
    end

    // Asynchronous reset while SCK is high.
    s0 = s_n;
    pulse_start(8'h01);
    for (int i = 0; i < 500 && !ADC_SCK; i++) @(negedge clk);
    check("rstmid_sck_seen", ADC_SCK, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rstmid_convst", ADC_CONVST, 1'b0);
    check("rstmid_sck", ADC_SCK, 1'b0);
    check("rstmid_sdi", ADC_SDI, 1'b0);
    check("rstmid_valid", result_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_nostrobe", s_n - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
